alu_issue_seq: RTL
==================

# alu_issue_seq

Sequencing initiator for the combinational ALU: accepts one operation request per transaction over a valid/ready handshake, drives registered operands and `ctrl` into the ALU, waits a configurable number of cycles for the multi-cycle-path ops (mod, mul), and captures the result and NZCV flags into a response register. It also owns the architectural flag register and, when enabled, predicates each operation on a condition code evaluated against that register. It sits between decode/issue and the ALU in the datapath.

## Interface

- `N`, 16: operand/result width; must match the ALU's `N`.
- `SLOW_CYCLES`, 3: wait cycles inserted before capture for ops `0100` (mod) and `0110` (mul). Range 0..15.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; high only in IDLE.
- `req_op`  in  4  ALU op code, same encoding as ALU `ctrl`.
- `req_a`, `req_b`  in  N  operands.
- `req_cond`  in  4  condition code.
- `req_setf`  in  1  update flag register on completion.
- `alu_a`, `alu_b`  out  N  registered operands to ALU.
- `alu_ctrl`  out  4  registered op to ALU.
- `alu_res`  in  N  ALU result.
- `alu_flags`  in  4  ALU flags: bit3 N, bit2 Z, bit1 C, bit0 V.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_res`  out  N  captured result (0 if skipped).
- `rsp_flags`  out  4  captured ALU flags (flag register copy if skipped).
- `rsp_skipped`  out  1  condition failed, op not executed.
- `flag_reg`  out  4  architectural NZCV register.

## Operation

- FSM states: IDLE, WAIT, EXEC, DONE. Reset state IDLE.
- IDLE: `req_ready`=1. On `req_valid`: latch `req_a/b/op` into `alu_a/b/ctrl`, latch `req_setf`, evaluate `req_cond` against current `flag_reg`.
  - Condition false -> DONE, `rsp_skipped`=1, `rsp_res`=0, `rsp_flags`=`flag_reg`.
  - Condition true, op in {0100, 0110} and `SLOW_CYCLES`>0 -> WAIT, counter loaded with `SLOW_CYCLES`.
  - Otherwise -> EXEC.
- WAIT: counter decrements each cycle; at 1 -> EXEC (exactly `SLOW_CYCLES` cycles in WAIT).
- EXEC: one cycle; at its end capture `alu_res`->`rsp_res`, `alu_flags`->`rsp_flags`, `rsp_skipped`=0; if setf latched, `flag_reg`<=`alu_flags`. -> DONE.
- DONE: `rsp_valid`=1; rsp_* held stable. On `rsp_ready` -> IDLE. No new request accepted in DONE.
- `alu_a/b/ctrl` hold last values outside a transaction.
- Condition codes vs `flag_reg` {N,Z,C,V}: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 GE N==V; 1001 LT N!=V; 1010 GT !Z&(N==V); 1011 LE Z|(N!=V); 1100–1111 always.
- Skipped ops never modify `flag_reg`.

## Timing

- Reset (async assert, any state): state IDLE, `req_ready`=1 after reset release, `rsp_valid`=0, `rsp_res`=0, `rsp_flags`=0, `rsp_skipped`=0, `flag_reg`=0, `alu_a`=`alu_b`=0, `alu_ctrl`=0, counter 0. In-flight op discarded, no response.
- Accept at edge k (req_valid & req_ready):
  - skipped: `rsp_valid` high from k+1.
  - fast op: EXEC cycle k..k+1, `rsp_valid` high from k+2.
  - slow op: `rsp_valid` high from k+2+`SLOW_CYCLES`.
- `flag_reg` updates on the same edge `rsp_valid` rises.
- Response handshake at edge m -> `rsp_valid`=0, `req_ready`=1 from m; earliest next accept at edge m+1.
- Back-to-back dependent ops see updated `flag_reg` (no forwarding needed; flags commit before next accept).

## Configuration

- `ALU_COND_EXEC_EN` defined: condition evaluation as above; skipped responses possible.
- Undefined: `req_cond` ignored, every op executes, `rsp_skipped` tied 0; `flag_reg` and `req_setf` behave unchanged.

## Test plan

- Reset, then add (0000) 0x0005+0x0003, cond 1110, setf=1 -> `rsp_res`=0x0008, `rsp_flags`=0000, `rsp_valid` at accept+2, `flag_reg`=0000.
- sub (0001) 0x0003-0x0003 setf=1 -> `rsp_res`=0x0000, `rsp_flags`=0110, `flag_reg`=0110; then add 0x0001+0x0001 cond EQ -> `rsp_res`=0x0002, `rsp_skipped`=0.
- With Z set, add cond NE -> `rsp_skipped`=1, `rsp_res`=0, `rsp_flags`=0110, `rsp_valid` at accept+1, `flag_reg` unchanged; without `ALU_COND_EXEC_EN` same op executes.
- mul (0110) 0x0004*0x0003, `SLOW_CYCLES`=3 -> `rsp_res`=0x000C at accept+5; `req_ready`=0 throughout.
- Hold `rsp_ready`=0 four cycles in DONE -> rsp_* stable, `req_ready`=0, `req_valid` ignored; release -> IDLE, next request accepted one edge later.
- Assert `rst_n`=0 during WAIT of a mod -> all outputs at reset values immediately, no response after release, `flag_reg`=0.

Source files
------------

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: issue/sequencing stage that feeds the combinational ALU and owns the NZCV flag register.
// Define ALU_COND_EXEC_EN to predicate each operation on req_cond evaluated against flag_reg.
module alu_issue_seq #(
    parameter int N           = 16,
    parameter int SLOW_CYCLES = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    input  logic [3:0]   req_cond,
    input  logic         req_setf,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    input  logic [N-1:0] alu_res,
    input  logic [3:0]   alu_flags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_res,
    output logic [3:0]   rsp_flags,
    output logic         rsp_skipped,
    output logic [3:0]   flag_reg
);

    // state  | meaning
    // S_IDLE | ready for a request, req_ready high
    // S_WAIT | multi-cycle-path settle time for mod/mul, down-counter running
    // S_EXEC | ALU inputs settled; result and flags captured at end of cycle
    // S_DONE | response held until rsp_ready
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_DONE} state_t;

    localparam logic [3:0] LP_SLOW = 4'(SLOW_CYCLES);

    state_t       r_state;
    logic [3:0]   r_cnt;
    logic         r_req_ready;
    logic         r_rsp_valid;
    logic [N-1:0] r_alu_a;
    logic [N-1:0] r_alu_b;
    logic [3:0]   r_alu_ctrl;
    logic         r_setf;
    logic [N-1:0] r_rsp_res;
    logic [3:0]   r_rsp_flags;
    logic         r_rsp_skipped;
    logic [3:0]   r_flag;

    logic         w_cond_ok;
    logic         w_slow_op;

`ifdef ALU_COND_EXEC_EN
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'b0000: return z;
            4'b0001: return !z;
            4'b0010: return cf;
            4'b0011: return !cf;
            4'b0100: return n;
            4'b0101: return !n;
            4'b0110: return v;
            4'b0111: return !v;
            4'b1000: return n == v;
            4'b1001: return n != v;
            4'b1010: return !z && (n == v);
            4'b1011: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    assign w_cond_ok = cond_pass(req_cond, r_flag);
`else
    logic w_unused_cond;
    assign w_unused_cond = ^req_cond;
    assign w_cond_ok     = 1'b1;
`endif

    assign w_slow_op = ((req_op == 4'b0100) || (req_op == 4'b0110)) && (SLOW_CYCLES > 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_ctrl    <= '0;
            r_setf        <= 1'b0;
            r_rsp_res     <= '0;
            r_rsp_flags   <= '0;
            r_rsp_skipped <= 1'b0;
            r_flag        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_alu_a     <= req_a;
                        r_alu_b     <= req_b;
                        r_alu_ctrl  <= req_op;
                        r_setf      <= req_setf;
                        r_req_ready <= 1'b0;
                        if (!w_cond_ok) begin
                            // Skipped op answers immediately and reports the unchanged flags
                            r_rsp_res     <= '0;
                            r_rsp_flags   <= r_flag;
                            r_rsp_skipped <= 1'b1;
                            r_rsp_valid   <= 1'b1;
                            r_state       <= S_DONE;
                        end else if (w_slow_op) begin
                            r_cnt   <= LP_SLOW;
                            r_state <= S_WAIT;
                        end else begin
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_res     <= alu_res;
                    r_rsp_flags   <= alu_flags;
                    r_rsp_skipped <= 1'b0;
                    r_rsp_valid   <= 1'b1;
                    if (r_setf) begin
                        r_flag <= alu_flags;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_ctrl    = r_alu_ctrl;
    assign rsp_res     = r_rsp_res;
    assign rsp_flags   = r_rsp_flags;
    assign rsp_skipped = r_rsp_skipped;
    assign flag_reg    = r_flag;

endmodule
